// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt responder.
// Contents: handler-sequencing state enum, code/mask widths, default vector
// table placement, and the vector-address helper used by the top level.
package irq_pkg;

    localparam int          IRQ_CODE_W    = 3;
    localparam int          MASK_W        = 7;
    localparam int          ADDR_W_DEF    = 15;
    localparam logic [14:0] VEC_BASE_DEF  = 15'h0010;
    localparam int unsigned VEC_SHIFT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PEND  = 3'd1,
        ENTER = 3'd2,
        ISR   = 3'd3,
        LEAVE = 3'd4
    } irq_state_e;

    // Vector = base + (code << shift). Computed at 32 bits; the caller
    // truncates to its address width, which gives the modulo-2^ADDR_W wrap.
    function automatic logic [31:0] vec_addr(input logic [31:0]           base,
                                             input logic [IRQ_CODE_W-1:0] code,
                                             input int unsigned           shift);
        logic [31:0] offset;
        offset = {29'd0, code} << shift;
        return base + offset;
    endfunction

endpackage

// File: rtl/irq_pending_slot.sv
// One-entry pending-interrupt slot.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   code_i          incoming code from the queue (nonzero = valid this cycle)
//   free_i          the held code is being taken by the handler this cycle
//   valid_o/code_o  registered slot contents
//   valid_next_o    slot valid in the next cycle (lets the FSM leave IDLE/LEAVE
//                   in step with a capture)
//   overflow_o      sticky: a code arrived while the slot was occupied
module irq_pending_slot
    import irq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IRQ_CODE_W-1:0] code_i,
    input  logic                  free_i,
    output logic                  valid_o,
    output logic [IRQ_CODE_W-1:0] code_o,
    output logic                  valid_next_o,
    output logic                  overflow_o
);

    logic                  valid_q, valid_d;
    logic [IRQ_CODE_W-1:0] code_q, code_d;
    logic                  ovf_q, ovf_d;
    logic                  open_s;
    logic                  arrive_s;

    // Capture, free and overflow decisions for the next cycle.
    always_comb begin
        arrive_s = (code_i != 3'd0);
        // Freeing and arriving in the same cycle counts as an empty slot.
        open_s   = ~valid_q | free_i;
        if (arrive_s && open_s) begin
            valid_d = 1'b1;
            code_d  = code_i;
        end else if (free_i) begin
            valid_d = 1'b0;
            code_d  = 3'd0;
        end else begin
            valid_d = valid_q;
            code_d  = code_q;
        end
        ovf_d = ovf_q | (arrive_s & ~open_s);
    end

    // Slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            code_q  <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o      = valid_q;
    assign code_o       = code_q;
    assign valid_next_o = valid_d;
    assign overflow_o   = ovf_q;

endmodule

// File: rtl/irq_responder.sv
// Core-side interrupt responder: holds one pending code, redirects fetch to
// its vector at an instruction boundary when enabled and unmasked, saves the
// return address, and on reti redirects back and pulses eirq to the queue.
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   irq1..irq3              code bits 0..2 from the queue
//   pc                      address of the next instruction
//   boundary, reti          core status strobes
//   ie_set, ie_clr          global enable control (clear wins)
//   mask_we, mask_in        per-code enable mask write
//   redirect, redirect_addr fetch redirect strobe and target (registered)
//   eirq                    end-of-interrupt pulse (registered)
//   in_isr, irq_num         handler active and its code (registered)
//   overflow                sticky pending-slot overflow
module irq_responder
    import irq_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  VEC_BASE  = VEC_BASE_DEF,
    parameter int unsigned        VEC_SHIFT = VEC_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq1,
    input  logic              irq2,
    input  logic              irq3,
    input  logic [ADDR_W-1:0] pc,
    input  logic              boundary,
    input  logic              reti,
    input  logic              ie_set,
    input  logic              ie_clr,
    input  logic              mask_we,
    input  logic [MASK_W-1:0] mask_in,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic              eirq,
    output logic              in_isr,
    output logic [2:0]        irq_num,
    output logic              overflow
);

    irq_state_e            state_q, state_d;
    logic                  ie_q, ie_d;
    logic [MASK_W-1:0]     mask_q, mask_d;
    logic [ADDR_W-1:0]     saved_pc_q, saved_pc_d;

    logic                  redirect_q, redirect_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  eirq_q, eirq_d;
    logic                  in_isr_q, in_isr_d;
    logic [2:0]            irq_num_q, irq_num_d;

    logic                  slot_valid_s;
    logic                  slot_valid_next_s;
    logic [IRQ_CODE_W-1:0] slot_code_s;
    logic                  take_s;
    logic                  leave_s;
    logic [ADDR_W-1:0]     vector_s;

    irq_pending_slot u_slot (
        .clk          (clk),
        .rst          (rst),
        .code_i       ({irq3, irq2, irq1}),
        .free_i       (take_s),
        .valid_o      (slot_valid_s),
        .code_o       (slot_code_s),
        .valid_next_o (slot_valid_next_s),
        .overflow_o   (overflow)
    );

    // Entry/exit qualifiers and the vector for the held code.
    always_comb begin
        // In PEND the slot is always valid, so code-1 indexes bits 0..6.
        take_s   = (state_q == PEND) & slot_valid_s & boundary & ie_q
                 & mask_q[slot_code_s - 3'd1];
        leave_s  = (state_q == ISR) & reti;
        vector_s = ADDR_W'(vec_addr(32'(VEC_BASE), slot_code_s, VEC_SHIFT));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = slot_valid_next_s ? PEND : IDLE;
            PEND:    state_d = take_s ? ENTER : PEND;
            ENTER:   state_d = ISR;
            ISR:     state_d = leave_s ? LEAVE : ISR;
            LEAVE:   state_d = slot_valid_next_s ? PEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        redirect_d = 1'b0;
        addr_d     = {ADDR_W{1'b0}};
        eirq_d     = 1'b0;
        in_isr_d   = in_isr_q;
        irq_num_d  = irq_num_q;
        if (take_s) begin
            redirect_d = 1'b1;
            addr_d     = vector_s;
            in_isr_d   = 1'b1;
            irq_num_d  = slot_code_s;
        end else if (leave_s) begin
            redirect_d = 1'b1;
            addr_d     = saved_pc_q;
            eirq_d     = 1'b1;
            in_isr_d   = 1'b0;
            irq_num_d  = 3'd0;
        end else begin
            in_isr_d   = in_isr_q;
            irq_num_d  = irq_num_q;
        end
    end

    // Next values of enable, mask and return address.
    always_comb begin
        if (ie_clr) begin
            ie_d = 1'b0;
        end else if (ie_set) begin
            ie_d = 1'b1;
        end else begin
            ie_d = ie_q;
        end
        mask_d     = mask_we ? mask_in : mask_q;
        saved_pc_d = take_s ? pc : saved_pc_q;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q       <= 1'b0;
            mask_q     <= 7'h7F;
            saved_pc_q <= {ADDR_W{1'b0}};
            redirect_q <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            eirq_q     <= 1'b0;
            in_isr_q   <= 1'b0;
            irq_num_q  <= 3'd0;
        end else begin
            ie_q       <= ie_d;
            mask_q     <= mask_d;
            saved_pc_q <= saved_pc_d;
            redirect_q <= redirect_d;
            addr_q     <= addr_d;
            eirq_q     <= eirq_d;
            in_isr_q   <= in_isr_d;
            irq_num_q  <= irq_num_d;
        end
    end

    assign redirect      = redirect_q;
    assign redirect_addr = addr_q;
    assign eirq          = eirq_q;
    assign in_isr        = in_isr_q;
    assign irq_num       = irq_num_q;

endmodule

// File: tb/tb_irq_responder.sv
// Bench for irq_responder: directed scenarios followed by random traffic, all
// compared each cycle against a transaction-level reference model. A second
// instance with a high vector base exercises address wrap.
module tb_irq_responder;

    logic        clk = 1'b0;
    logic        rst, irq1, irq2, irq3, boundary, reti, ie_set, ie_clr, mask_we;
    logic [14:0] pc;
    logic [6:0]  mask_in;

    logic        redirect, eirq, in_isr, overflow;
    logic [14:0] redirect_addr;
    logic [2:0]  irq_num;
    logic        w_redirect, w_eirq, w_in_isr, w_overflow;
    logic [14:0] w_redirect_addr;
    logic [2:0]  w_irq_num;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit          m_pend;
    int          m_code;
    bit          m_ovf;
    bit          m_ie;
    bit   [6:0]  m_mask;
    int          m_phase;   // 0 free, 1 just entered, 2 in handler, 3 returning
    logic [14:0] m_ret;
    // Expected outputs.
    bit          e_redir, e_eirq, e_isr;
    int          e_num;
    logic [14:0] e_addr, e_addr_w;

    always #5 clk = ~clk;

    irq_responder dut (
        .clk(clk), .rst(rst), .irq1(irq1), .irq2(irq2), .irq3(irq3), .pc(pc),
        .boundary(boundary), .reti(reti), .ie_set(ie_set), .ie_clr(ie_clr),
        .mask_we(mask_we), .mask_in(mask_in), .redirect(redirect),
        .redirect_addr(redirect_addr), .eirq(eirq), .in_isr(in_isr),
        .irq_num(irq_num), .overflow(overflow)
    );

    irq_responder #(.VEC_BASE(15'h7FF0)) dut_w (
        .clk(clk), .rst(rst), .irq1(irq1), .irq2(irq2), .irq3(irq3), .pc(pc),
        .boundary(boundary), .reti(reti), .ie_set(ie_set), .ie_clr(ie_clr),
        .mask_we(mask_we), .mask_in(mask_in), .redirect(w_redirect),
        .redirect_addr(w_redirect_addr), .eirq(w_eirq), .in_isr(w_in_isr),
        .irq_num(w_irq_num), .overflow(w_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT samples.
    task automatic model_step();
        int  c;
        bit  take, leave;
        c = {irq3, irq2, irq1};
        e_redir = 1'b0;
        e_eirq  = 1'b0;
        if (rst) begin
            m_pend = 1'b0; m_code = 0; m_ovf = 1'b0; m_ie = 1'b0;
            m_mask = 7'h7F; m_phase = 0; m_ret = 15'h0000;
            e_isr = 1'b0; e_num = 0; e_addr = 15'h0000; e_addr_w = 15'h0000;
            return;
        end
        take  = (m_phase == 0) && m_pend && boundary && m_ie && m_mask[m_code-1];
        leave = (m_phase == 2) && reti;
        if (take) begin
            e_redir  = 1'b1;
            e_addr   = 15'(32'h0010 + (m_code << 2));
            e_addr_w = 15'(32'h7FF0 + (m_code << 2));
            m_ret    = pc;
            e_isr    = 1'b1;
            e_num    = m_code;
            m_pend   = 1'b0;
            m_phase  = 1;
        end else if (leave) begin
            e_redir  = 1'b1;
            e_addr   = m_ret;
            e_addr_w = m_ret;
            e_eirq   = 1'b1;
            e_isr    = 1'b0;
            e_num    = 0;
            m_phase  = 3;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 3) begin
            m_phase = 0;
        end
        if (c != 0) begin
            if (m_pend) m_ovf = 1'b1;
            else begin
                m_pend = 1'b1;
                m_code = c;
            end
        end
        if (ie_clr)      m_ie = 1'b0;
        else if (ie_set) m_ie = 1'b1;
        if (mask_we) m_mask = mask_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("redirect", redirect, e_redir);
        chk("eirq", eirq, e_eirq);
        chk("in_isr", in_isr, e_isr);
        chk("irq_num", irq_num, e_num);
        chk("overflow", overflow, m_ovf);
        chk("wrap_redirect", w_redirect, e_redir);
        if (e_redir) begin
            chk("redirect_addr", redirect_addr, e_addr);
            chk("wrap_redirect_addr", w_redirect_addr, e_addr_w);
        end
    endtask

    task automatic set_code(input int c);
        {irq3, irq2, irq1} = 3'(c);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; set_code(0); boundary = 1'b0; reti = 1'b0;
        ie_set = 1'b0; ie_clr = 1'b0; mask_we = 1'b0; mask_in = 7'h7F;
        pc = 15'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();

        // 1: reset, enable, code 3, enter at a boundary.
        do_reset();
        chk("reset_redirect", redirect, 1'b0);
        chk("reset_in_isr", in_isr, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        ie_set = 1'b1; tick(); ie_set = 1'b0;
        set_code(3); tick(); set_code(0);
        tick();
        boundary = 1'b1; pc = 15'h0123; tick(); boundary = 1'b0;
        chk("t1_redirect", redirect, 1'b1);
        chk("t1_addr", redirect_addr, 15'h001C);
        chk("t1_in_isr", in_isr, 1'b1);
        chk("t1_irq_num", irq_num, 3'd3);

        // 2: reti restores pc and pulses eirq once.
        repeat (5) tick();
        reti = 1'b1; tick(); reti = 1'b0;
        chk("t2_redirect", redirect, 1'b1);
        chk("t2_addr", redirect_addr, 15'h0123);
        chk("t2_eirq", eirq, 1'b1);
        chk("t2_in_isr", in_isr, 1'b0);
        tick();
        chk("t2_eirq_low", eirq, 1'b0);
        chk("t2_redirect_low", redirect, 1'b0);

        // 3: masked code waits; unmasking lets it in.
        mask_we = 1'b1; mask_in = 7'h7B; tick(); mask_we = 1'b0;
        set_code(3); tick(); set_code(0);
        boundary = 1'b1; pc = 15'h0456;
        repeat (4) begin
            tick();
            chk("t3_masked", redirect, 1'b0);
        end
        mask_we = 1'b1; mask_in = 7'h7F; tick(); mask_we = 1'b0;
        chk("t3_mask_delay", redirect, 1'b0);
        tick();
        chk("t3_unmasked", redirect, 1'b1);
        boundary = 1'b0;
        tick();
        reti = 1'b1; tick(); reti = 1'b0;
        tick(); tick();

        // 4: codes during the handler; second one overflows.
        set_code(2); tick(); set_code(0);
        boundary = 1'b1; pc = 15'h0200; tick(); boundary = 1'b0;
        tick();
        set_code(5); tick();
        set_code(6); tick(); set_code(0);
        chk("t4_overflow", overflow, 1'b1);
        tick();
        reti = 1'b1; tick(); reti = 1'b0;
        chk("t4_eirq", eirq, 1'b1);
        tick();
        boundary = 1'b1; pc = 15'h0300; tick(); boundary = 1'b0;
        chk("t4_next_addr", redirect_addr, 15'h0024);
        chk("t4_next_num", irq_num, 3'd5);
        tick();
        reti = 1'b1; tick(); reti = 1'b0;
        tick();

        // 5: set and clear together leaves ie off; reset mid-handler.
        set_code(1); tick(); set_code(0);
        ie_set = 1'b1; ie_clr = 1'b1; tick(); ie_set = 1'b0; ie_clr = 1'b0;
        boundary = 1'b1;
        tick(); tick();
        chk("t5_ie_cleared", redirect, 1'b0);
        ie_set = 1'b1; tick(); ie_set = 1'b0;
        tick();
        chk("t5_enter", redirect, 1'b1);
        boundary = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_rst_in_isr", in_isr, 1'b0);
        chk("t5_rst_num", irq_num, 3'd0);
        chk("t5_rst_overflow", overflow, 1'b0);
        tick();
        chk("t5_no_eirq", eirq, 1'b0);

        // 6: code 7 against the high vector base wraps.
        ie_set = 1'b1; tick(); ie_set = 1'b0;
        set_code(7); tick(); set_code(0);
        boundary = 1'b1; pc = 15'h0777; tick(); boundary = 1'b0;
        chk("t6_wrap_addr", w_redirect_addr, 15'h000C);
        chk("t6_addr", redirect_addr, 15'h002C);
        tick();
        reti = 1'b1; tick(); reti = 1'b0;
        tick();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            set_code(($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0);
            boundary = $urandom_range(0, 1);
            reti     = ($urandom_range(0, 7) == 0);
            ie_set   = ($urandom_range(0, 9) == 0);
            ie_clr   = ($urandom_range(0, 29) == 0);
            mask_we  = ($urandom_range(0, 39) == 0);
            mask_in  = 7'($urandom);
            pc       = 15'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
